// File: rtl/cpu_pkg.sv
// Shared types for the sequential SM83 ALU: operation codes, flag bit
// positions inside {Z,N,H,C}, and the sequencer states.
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP,
    OP_INC, OP_DEC,
    OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SWAP, OP_SRL,
    OP_BIT, OP_RES, OP_SET,
    OP_DAA, OP_CPL, OP_SCF, OP_CCF,
    OP_ADD16, OP_INC16, OP_DEC16
  } alu_op_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_H = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  function automatic logic is_single_slice(alu_op_t op);
    case (op)
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SWAP, OP_SRL,
      OP_BIT, OP_RES, OP_SET, OP_DAA, OP_CPL, OP_SCF, OP_CCF:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu_slice.sv
// Combinational WIDTH-bit ALU slice. Add/sub ops chain through carry_in;
// for subtract-class ops carry_in/carry_out are borrows.
module cpu_alu_slice
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [2:0]       bit_sel,
  input  logic [2:0]       flags,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             half_carry,
  output logic             zero
);
  localparam int HALF = WIDTH / 2;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] daa_corr;
  logic             hc_add;
  logic             hc_sub;
  logic             daa_lo;
  logic             daa_hi;

  assign sum    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(carry_in);
  assign diff   = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(carry_in);
  assign hc_add = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(carry_in)) > 5'd15;
  assign hc_sub = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + 5'(carry_in));
  assign mask   = WIDTH'(1) << bit_sel;

  // After a subtraction DAA only undoes what H/C report; after an addition
  // it also corrects out-of-range BCD digits.
  assign daa_lo   = flags[FLAG_N] ? flags[FLAG_H] : (flags[FLAG_H] | (a[3:0] > 4'h9));
  assign daa_hi   = flags[FLAG_N] ? flags[FLAG_C] : (flags[FLAG_C] | (a > WIDTH'('h99)));
  assign daa_corr = (daa_hi ? WIDTH'('h60) : '0) | (daa_lo ? WIDTH'(6) : '0);

  always_comb begin
    result     = a;
    carry_out  = 1'b0;
    half_carry = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_INC, OP_ADD16, OP_INC16: begin
        result     = sum[WIDTH-1:0];
        carry_out  = sum[WIDTH];
        half_carry = hc_add;
      end
      OP_SUB, OP_SBC, OP_DEC, OP_DEC16: begin
        result     = diff[WIDTH-1:0];
        carry_out  = diff[WIDTH];
        half_carry = hc_sub;
      end
      OP_CP: begin
        carry_out  = diff[WIDTH];
        half_carry = hc_sub;
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_RLC:  begin result = {a[WIDTH-2:0], a[WIDTH-1]}; carry_out = a[WIDTH-1]; end
      OP_RRC:  begin result = {a[0], a[WIDTH-1:1]};       carry_out = a[0];       end
      OP_RL:   begin result = {a[WIDTH-2:0], carry_in};   carry_out = a[WIDTH-1]; end
      OP_RR:   begin result = {carry_in, a[WIDTH-1:1]};   carry_out = a[0];       end
      OP_SLA:  begin result = {a[WIDTH-2:0], 1'b0};       carry_out = a[WIDTH-1]; end
      OP_SRA:  begin result = {a[WIDTH-1], a[WIDTH-1:1]}; carry_out = a[0];       end
      OP_SRL:  begin result = {1'b0, a[WIDTH-1:1]};       carry_out = a[0];       end
      OP_SWAP: result = {a[HALF-1:0], a[WIDTH-1:HALF]};
      OP_RES:  result = a & ~mask;
      OP_SET:  result = a | mask;
      OP_DAA: begin
        result    = flags[FLAG_N] ? (a - daa_corr) : (a + daa_corr);
        carry_out = daa_hi;
      end
      OP_CPL:  result = ~a;
      OP_SCF:  carry_out = 1'b1;
      OP_CCF:  carry_out = ~flags[FLAG_C];
      default: result = a;
    endcase

    zero = (result == '0);
    if (op == OP_CP)
      zero = (diff[WIDTH-1:0] == '0);
    else if (op == OP_BIT)
      zero = ~|(a & mask);
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// Multi-cycle SM83 ALU: one WIDTH-bit slice per clock, LSB first, with
// valid/ready handshakes toward the control unit and the register file.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | computing slice k, carry chained to slice k+1
// DONE  | result held with out_valid=1 until out_ready
module cpu_alu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHAIN_MAX = 2,
  parameter int CLW       = $clog2(CHAIN_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  alu_op_t                    op,
  input  logic [2:0]                 bit_sel,
  input  logic [CLW-1:0]             chain_len,
  input  logic [WIDTH*CHAIN_MAX-1:0] a,
  input  logic [WIDTH*CHAIN_MAX-1:0] b,
  input  logic [3:0]                 flags_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*CHAIN_MAX-1:0] result,
  output logic [3:0]                 flags_out
);
  localparam int TW = WIDTH * CHAIN_MAX;

  alu_state_t       state, state_nxt;
  alu_op_t          op_r;
  logic [2:0]       bit_sel_r;
  logic [TW-1:0]    a_r, b_r, b_eff, result_r;
  logic [3:0]       flags_r, flags_o_r, flags_nxt;
  logic [CLW-1:0]   k, last_r, last_nxt;
  logic             carry_r, carry_init, z_acc, z_all;
  logic             accept, step;
  logic [WIDTH-1:0] s_res;
  logic             s_co, s_hc, s_zero;

  always_comb begin
    if (is_single_slice(op) || chain_len == '0)
      last_nxt = '0;
    else if (chain_len > CLW'(CHAIN_MAX))
      last_nxt = CLW'(CHAIN_MAX - 1);
    else
      last_nxt = chain_len - CLW'(1);
  end

  // DEC16 subtracts zero with an initial borrow so every slice runs the SUB path.
  always_comb begin
    b_eff      = b;
    carry_init = 1'b0;
    case (op)
      OP_INC, OP_DEC, OP_INC16: b_eff = TW'(1);
      OP_DEC16: begin b_eff = '0; carry_init = 1'b1; end
      OP_ADC, OP_SBC, OP_RL, OP_RR: carry_init = flags_in[FLAG_C];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (k == last_r) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = BUSY;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  cpu_alu_slice #(.WIDTH(WIDTH)) u_slice (
    .op        (op_r),
    .a         (a_r[WIDTH-1:0]),
    .b         (b_r[WIDTH-1:0]),
    .carry_in  (carry_r),
    .bit_sel   (bit_sel_r),
    .flags     (flags_r[2:0]),
    .result    (s_res),
    .carry_out (s_co),
    .half_carry(s_hc),
    .zero      (s_zero)
  );

  always_comb begin
    z_all     = z_acc & s_zero;
    flags_nxt = flags_r;
    case (op_r)
      OP_ADD, OP_ADC:         flags_nxt = {z_all, 1'b0, s_hc, s_co};
      OP_INC:                 flags_nxt = {z_all, 1'b0, s_hc, flags_r[FLAG_C]};
      OP_SUB, OP_SBC, OP_CP:  flags_nxt = {z_all, 1'b1, s_hc, s_co};
      OP_DEC:                 flags_nxt = {z_all, 1'b1, s_hc, flags_r[FLAG_C]};
      OP_AND:                 flags_nxt = {z_all, 1'b0, 1'b1, 1'b0};
      OP_OR, OP_XOR:          flags_nxt = {z_all, 1'b0, 1'b0, 1'b0};
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SWAP, OP_SRL:
                              flags_nxt = {z_all, 1'b0, 1'b0, s_co};
      OP_BIT:                 flags_nxt = {s_zero, 1'b0, 1'b1, flags_r[FLAG_C]};
      OP_DAA:                 flags_nxt = {z_all, flags_r[FLAG_N], 1'b0, s_co};
      OP_CPL:                 flags_nxt = {flags_r[FLAG_Z], 1'b1, 1'b1, flags_r[FLAG_C]};
      OP_SCF, OP_CCF:         flags_nxt = {flags_r[FLAG_Z], 1'b0, 1'b0, s_co};
      OP_ADD16:               flags_nxt = {flags_r[FLAG_Z], 1'b0, s_hc, s_co};
      default:                flags_nxt = flags_r;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r      <= OP_ADD;
      bit_sel_r <= '0;
      a_r       <= '0;
      b_r       <= '0;
      flags_r   <= '0;
      last_r    <= '0;
      k         <= '0;
      carry_r   <= 1'b0;
      z_acc     <= 1'b0;
      result_r  <= '0;
      flags_o_r <= '0;
    end else if (accept) begin
      op_r      <= op;
      bit_sel_r <= bit_sel;
      a_r       <= a;
      b_r       <= b_eff;
      flags_r   <= flags_in;
      last_r    <= last_nxt;
      k         <= '0;
      carry_r   <= carry_init;
      z_acc     <= 1'b1;
      result_r  <= '0;
      flags_o_r <= '0;
    end else if (step) begin
      for (int i = 0; i < CHAIN_MAX; i++)
        if (k == CLW'(i)) result_r[i*WIDTH +: WIDTH] <= s_res;
      a_r     <= a_r >> WIDTH;
      b_r     <= b_r >> WIDTH;
      carry_r <= s_co;
      z_acc   <= z_all;
      k       <= k + CLW'(1);
      if (k == last_r) flags_o_r <= flags_nxt;
    end
  end

  assign result    = result_r;
  assign flags_out = flags_o_r;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed-vector bench for cpu_alu_seq; expected results go into a queue
// at request acceptance and a monitor compares them at each output handshake.
module tb_cpu_alu_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  alu_op_t     op;
  logic [2:0]  bit_sel;
  logic [1:0]  chain_len;
  logic [15:0] a, b;
  logic [3:0]  flags_in;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic [3:0]  flags_out;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tag_cnt = 0;

  cpu_alu_seq #(.WIDTH(8), .CHAIN_MAX(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .bit_sel  (bit_sel),
    .chain_len(chain_len),
    .a        (a),
    .b        (b),
    .flags_in (flags_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: result 0x%0h flags %b", result, flags_out);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("sb#%0d result", e.tag), result, e.res);
          chk($sformatf("sb#%0d flags", e.tag), 16'(flags_out), 16'(e.flg));
        end
      end
    end
  end

  task automatic drive(input alu_op_t o, input logic [2:0] bs, input logic [1:0] cl,
                       input logic [15:0] av, input logic [15:0] bv, input logic [3:0] fi);
    op = o; bit_sel = bs; chain_len = cl; a = av; b = bv; flags_in = fi;
    in_valid = 1'b1;
  endtask

  task automatic accept(input logic [15:0] er, input logic [3:0] ef, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept timeout: in_ready 0 after %0d cycles", waited);
    end else begin
      e.res = er; e.flg = ef; e.tag = tag_cnt++;
      sb_q.push_back(e);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input int elat);
    int c = 1;
    @(negedge clk);
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("latency tag%0d", tag_cnt - 1), out_valid ? 16'(c) : 16'hffff, 16'(elat));
  endtask

  task automatic send(input alu_op_t o, input logic [2:0] bs, input logic [1:0] cl,
                      input logic [15:0] av, input logic [15:0] bv, input logic [3:0] fi,
                      input logic [15:0] er, input logic [3:0] ef, input int elat);
    int w;
    @(posedge clk);
    #1 drive(o, bs, cl, av, bv, fi);
    accept(er, ef, w);
    wait_out(elat);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int w;
    int seen;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_ADD; bit_sel = '0; chain_len = 2'd1; a = '0; b = '0; flags_in = '0;
    #2;
    chk("reset out_valid", 16'(out_valid), 16'd0);
    chk("reset result", result, 16'h0000);
    chk("reset flags", 16'(flags_out), 16'd0);
    #10 reset_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready", 16'(in_ready), 16'd1);

    //    op         bit  cl  a        b        fin      result   flags    lat
    send(OP_ADD,   0, 1, 16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011, 2);
    send(OP_ADD16, 0, 2, 16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010, 3);
    send(OP_SBC,   0, 1, 16'h003B, 16'h002A, 4'b0001, 16'h0010, 4'b0100, 2);
    send(OP_CP,    0, 1, 16'h003C, 16'h003C, 4'b0000, 16'h003C, 4'b1100, 2);
    send(OP_SWAP,  0, 1, 16'h00F0, 16'h0000, 4'b0000, 16'h000F, 4'b0000, 2);
    send(OP_BIT,   7, 2, 16'h007F, 16'h0000, 4'b0001, 16'h007F, 4'b1011, 2);
    send(OP_INC16, 0, 2, 16'hFFFF, 16'h0000, 4'b0101, 16'h0000, 4'b0101, 3);
    send(OP_ADD16, 0, 2, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 3);
    send(OP_DEC16, 0, 2, 16'h0000, 16'h0000, 4'b1010, 16'hFFFF, 4'b1010, 3);
    send(OP_ADC,   0, 2, 16'h00FF, 16'h0000, 4'b0001, 16'h0100, 4'b0000, 3);
    send(OP_AND,   0, 1, 16'h00F0, 16'h003C, 4'b0000, 16'h0030, 4'b0010, 2);
    send(OP_XOR,   0, 1, 16'h005A, 16'h005A, 4'b0000, 16'h0000, 4'b1000, 2);
    send(OP_OR,    0, 1, 16'h000F, 16'h00F0, 4'b0001, 16'h00FF, 4'b0000, 2);
    send(OP_SUB,   0, 1, 16'h0010, 16'h0001, 4'b0000, 16'h000F, 4'b0110, 2);
    send(OP_DEC,   0, 1, 16'h0001, 16'h0055, 4'b0001, 16'h0000, 4'b1101, 2);
    send(OP_RL,    0, 1, 16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001, 2);
    send(OP_RLC,   0, 1, 16'h0080, 16'h0000, 4'b0000, 16'h0001, 4'b0001, 2);
    send(OP_DAA,   0, 1, 16'h003C, 16'h0000, 4'b0000, 16'h0042, 4'b0000, 2);
    send(OP_DAA,   0, 1, 16'h009A, 16'h0000, 4'b0000, 16'h0000, 4'b1001, 2);
    send(OP_CPL,   0, 1, 16'h0035, 16'h0000, 4'b0000, 16'h00CA, 4'b0110, 2);
    send(OP_SCF,   0, 1, 16'h0012, 16'h0000, 4'b1000, 16'h0012, 4'b1001, 2);
    send(OP_CCF,   0, 1, 16'h0012, 16'h0000, 4'b0001, 16'h0012, 4'b0000, 2);
    send(OP_SET,   0, 1, 16'h0000, 16'h0000, 4'b1010, 16'h0001, 4'b1010, 2);
    send(OP_RES,   7, 1, 16'h00FF, 16'h0000, 4'b0000, 16'h007F, 4'b0000, 2);
    send(OP_ADD,   0, 0, 16'h0001, 16'h0001, 4'b0000, 16'h0002, 4'b0000, 2);

    // Backpressure then a back-to-back accept from DONE.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(OP_ADD,   0, 1, 16'h0012, 16'h0034, 4'b0000, 16'h0046, 4'b0000, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", i), 16'(out_valid), 16'd1);
      chk($sformatf("stall%0d result", i), result, 16'h0046);
      chk($sformatf("stall%0d in_ready", i), 16'(in_ready), 16'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drive(OP_INC, 0, 1, 16'h00FF, 16'h0000, 4'b0001);
    accept(16'h0000, 4'b1011, w);
    chk("b2b accept wait", 16'(w), 16'd0);
    wait_out(2);

    // Reset during BUSY of an ADD16.
    @(posedge clk);
    #1 drive(OP_ADD16, 0, 2, 16'h1111, 16'h2222, 4'b0000);
    accept(16'h3333, 4'b0000, w);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset out_valid", 16'(out_valid), 16'd0);
    chk("midreset result", result, 16'h0000);
    chk("midreset flags", 16'(flags_out), 16'd0);
    sb_q.delete();
    #4 reset_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 16'(in_ready), 16'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post-reset stale out_valid", 16'(seen), 16'd0);

    chk("scoreboard drained", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_alu_seq.md
Name: cpu_alu_seq

Overview:
- Multi-cycle, parametrised SM83 ALU that replaces the CPU's single-cycle combinational 8-bit ALU.
- Processes operands one WIDTH-bit slice per clock, LSB slice first, chaining carry between slices. This supports 8-bit instruction ALU ops, CB-prefix shifts/bit ops, DAA/CPL/SCF/CCF, and chained 16-bit adds (ADD HL,rr; INC/DEC rr) over multiple cycles.
- Sits between the control unit and the register file, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, slice width in bits; must be a multiple of 4 (half-carry taken from bit 3 of each slice).
- CHAIN_MAX, 2, maximum number of slices per operation; operand width is WIDTH*CHAIN_MAX.
- CLW, $clog2(CHAIN_MAX+1), width of chain_len.

Ports:
- clk  in  1  system clock (4 MHz nominal).
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  5  alu_op_t operation code (see Decomposition).
- bit_sel  in  3  bit index for BIT/RES/SET (slice 0 only).
- chain_len  in  CLW  slices to process, 1..CHAIN_MAX; 0 is treated as 1.
- a  in  WIDTH*CHAIN_MAX  operand A.
- b  in  WIDTH*CHAIN_MAX  operand B.
- flags_in  in  4  {Z,N,H,C} = F[7:4] at request time.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH*CHAIN_MAX  result; slices above chain_len are 0.
- flags_out  out  4  {Z,N,H,C}.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; out_valid=0; result=0; flags_out=0; slice counter=0; operand/carry registers=0. in_ready=1 once reset_n=1.
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid. Latch op, bit_sel, a, b, flags_in, chain_len. Carry register = flags_in.C for ADC/SBC/RL/RR, else 0 (1 for DEC16 borrow handling via SUB path). Go to BUSY with k=0.
  - BUSY: each cycle compute slice k and write it into the result register. Carry-out feeds slice k+1. When k==chain_len-1, go to DONE; else k++.
  - DONE: out_valid=1; result and flags_out stable. If out_ready=1: in_ready=1 combinationally. If in_valid is also 1, accept the new request and go directly to BUSY (back-to-back); otherwise go to IDLE.
- Latency: request accepted at cycle 0 -> out_valid asserted at cycle chain_len+1. Throughput: one op per chain_len+1 cycles with out_ready held high.
- Op set:
  - ADD, ADC, SUB, SBC, AND, XOR, OR, CP: SM83 semantics per slice. CP leaves result=a.
  - INC, DEC: b ignored, operand 1.
  - RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL, BIT, RES, SET: slice 0 only; chain_len is forced to 1.
  - DAA, CPL, SCF, CCF: slice 0 only; SM83 flag semantics.
  - ADD16, INC16, DEC16: chained add/sub across slices.
- Flag rules:
  - H: half-carry of the final slice.
  - C: carry-out of the final slice.
  - Z: 1 iff all processed slices are 0, except ADD16 where Z = flags_in.Z.
  - INC16/DEC16: all flags = flags_in.
  - AND: H=1. OR/XOR: H=0, C=0.
  - SUB/SBC/CP/DEC: N=1.
  - BIT: Z = ~bit, N=0, H=1, C unchanged.
  - RES/SET: flags = flags_in.
- Wrap-around: 0xFFFF+1 in INC16 -> 0x0000, flags unchanged. ADD16 0xFFFF+0x0001 -> 0x0000, C=1, H=1.
- in_valid while BUSY: ignored (in_ready=0); the requester must hold its request.
- reset_n asserted mid-op: the operation is abandoned and no out_valid is produced.

Decomposition:
- Shared package cpu_pkg holds:
  - alu_op_t enum (5-bit).
  - FLAG_C/H/N/Z index constants: 0/1/2/3.
  - alu_state_t enum {IDLE, BUSY, DONE}.
- One sub-module: cpu_alu_slice, a combinational WIDTH-bit slice.
  - Inputs: op, a, b, carry_in, bit_sel.
  - Outputs: result, carry_out, half_carry, zero.
- Top-level cpu_alu_seq owns the FSM, counters, and result/flag registers.

Test Plan:
- ADD, WIDTH=8, chain_len=1: a=0x3A, b=0xC6, flags_in=0 -> out_valid at cycle 2; result=0x00, flags_out=Z1 N0 H1 C1 (4'b1011).
- ADD16, chain_len=2: a=0x8A23, b=0x0605, flags_in.Z=1 -> result=0x9028, flags_out=Z1 N0 H1 C0 (4'b1010); out_valid at cycle 3.
- SBC with flags_in.C=1: a=0x3B, b=0x2A -> result=0x10, flags_out=4'b0100. CP a=0x3C b=0x3C -> result=0x3C, flags_out=4'b1100.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles -> result/out_valid stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (INC, a=0xFF) -> new op accepted the same cycle; next result=0x00, Z=1, H=1, C preserved.
- Reset mid-op: assert reset_n=0 asynchronously during BUSY of an ADD16 -> out_valid, result, flags_out immediately 0. After release, in_ready=1 and no stale result appears.
- CB ops: SWAP a=0xF0 -> 0x0F, flags 4'b0000. BIT bit_sel=7 a=0x7F, flags_in.C=1 -> Z=1 H=1 C=1. Request with chain_len=2 -> completes in 1 slice.
